// File: rtl/hazard_scoreboard.sv
// Tracks in-flight long-latency register writes and stalls ID on unresolved hazards.
// Per-register pending counters plus a drain FSM that quiesces issue on request.
module hazard_scoreboard #(
  parameter int unsigned CW  = 2,
  parameter int unsigned SCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [4:0]     id_rs,
  input  logic [4:0]     id_rt,
  input  logic           id_uses_rs,
  input  logic           id_uses_rt,
  input  logic [4:0]     id_rd,
  input  logic           id_we,
  input  logic           wb_valid,
  input  logic [4:0]     wb_rd,
  input  logic           drain_req,
  output logic           stall,
  output logic           issue,
  output logic           drained,
  output logic [31:0]    pending,
  output logic [SCW-1:0] stall_cycles,
  output logic           wb_underflow
);

  localparam int unsigned NREG = 32;
  localparam logic [CW-1:0] CNT_FULL = '1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [CW-1:0]   cnt [NREG];
  logic [0:0]      state;
  logic [0:0]      state_nxt;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] eff_busy;
  logic [NREG-1:0] inc;
  logic [NREG-1:0] dec;
  logic            hazard;

  // Per-register status; a same-cycle writeback retiring the last write clears the hazard.
  always_comb begin
    busy     = '0;
    eff_busy = '0;
    inc      = '0;
    dec      = '0;
    for (int r = 1; r < NREG; r++) begin
      busy[r]     = (cnt[r] != '0);
      dec[r]      = wb_valid && (wb_rd == 5'(r)) && busy[r];
      eff_busy[r] = busy[r] && !(dec[r] && (cnt[r] == CNT_ONE));
      inc[r]      = issue && id_we && (id_rd == 5'(r));
    end
  end

  always_comb begin
    hazard = (id_uses_rs && eff_busy[id_rs]) ||
             (id_uses_rt && eff_busy[id_rt]) ||
             (id_we && (id_rd != 5'd0) && (cnt[id_rd] == CNT_FULL));
    stall   = id_valid && (hazard || (state != ST_RUN));
    issue   = id_valid && !stall;
    drained = (state == ST_DRAIN) && (busy == '0);
    pending = busy;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (drain_req)  state_nxt = ST_DRAIN;
      ST_DRAIN: if (!drain_req) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Simultaneous increment and decrement on one register cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        case ({inc[r], dec[r]})
          2'b10:   cnt[r] <= cnt[r] + CNT_ONE;
          2'b01:   cnt[r] <= cnt[r] - CNT_ONE;
          default: cnt[r] <= cnt[r];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      wb_underflow <= 1'b0;
    end else begin
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + SCW'(1);
      if (wb_valid && (wb_rd != 5'd0) && !busy[wb_rd]) wb_underflow <= 1'b1;
    end
  end

endmodule
